// File: rtl/basilisk_memory_arbiter_if.sv
// Shared-memory arbiter bus: per-port request/response lanes plus the single memory port.
// The arbiter takes the slave modport; requesters and memory model take master.
interface basilisk_memory_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_W = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_read_enable;
  logic [NUM_PORTS*MASK_W-1:0]     req_write_enable;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_read_enable;
  logic [MASK_W-1:0]     mem_req_write_enable;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_data;

  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  logic [NUM_PORTS-1:0]  resp_valid;
  logic [NUM_PORTS-1:0]  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport slave (
    input  req_valid, req_read_enable, req_write_enable, req_addr, req_data,
           mem_req_ready, mem_resp_valid, mem_resp_data, resp_ready,
    output req_ready, mem_req_valid, mem_req_read_enable, mem_req_write_enable,
           mem_req_addr, mem_req_data, mem_resp_ready, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_read_enable, req_write_enable, req_addr, req_data,
           mem_req_ready, mem_resp_valid, mem_resp_data, resp_ready,
    input  req_ready, mem_req_valid, mem_req_read_enable, mem_req_write_enable,
           mem_req_addr, mem_req_data, mem_resp_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/basilisk_memory_arbiter.sv
// Round-robin arbiter sharing one memory port; an in-order tag FIFO steers read data back.
// Optional counters: define BASILISK_MEMORY_ARBITER_STATS_EN.
module basilisk_memory_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic clk,
  input  logic rst,
  basilisk_memory_arbiter_if.slave bus,
`ifdef BASILISK_MEMORY_ARBITER_STATS_EN
  output logic [31:0] conflict_count,
  output logic [31:0] full_stall_count,
`endif
  output logic protocol_error
);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int P      = $clog2(NUM_PORTS);
  localparam int AW     = $clog2(MAX_OUTSTANDING);

  logic [P-1:0]  rr_ptr, lock_g, gsel, g, head;
  logic          locked, found, hs, push, pop;
  logic [NUM_PORTS-1:0] elig;
  logic [P-1:0]  tags [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;
  int            idx;

  assign fifo_full  = (count == (AW+1)'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign elig = bus.req_valid & ~(bus.req_read_enable & {NUM_PORTS{fifo_full}});

  // Search starts at rr_ptr; a stalled grant is pinned by the lock so the bus stays stable.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gsel  = P'(idx);
      end
    end
  end

  assign g                        = locked ? lock_g : gsel;
  assign bus.mem_req_valid        = locked ? bus.req_valid[lock_g] : found;
  assign bus.mem_req_read_enable  = bus.req_read_enable[g];
  assign bus.mem_req_write_enable = bus.req_write_enable[int'(g)*MASK_W +: MASK_W];
  assign bus.mem_req_addr         = bus.req_addr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.mem_req_data         = bus.req_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
  assign hs   = bus.mem_req_valid && bus.mem_req_ready;
  assign push = hs && bus.mem_req_read_enable;

  always_comb begin
    bus.req_ready = '0;
    if (bus.mem_req_valid) bus.req_ready[g] = bus.mem_req_ready;
  end

  assign head = tags[rd_ptr];
  assign pop  = bus.mem_resp_valid && !fifo_empty && bus.resp_ready[head];
  assign bus.resp_data = bus.mem_resp_data;
  // With nothing outstanding a stray beat is accepted and dropped so the memory never wedges.
  assign bus.mem_resp_ready = fifo_empty ? bus.mem_resp_valid : bus.resp_ready[head];

  always_comb begin
    bus.resp_valid = '0;
    if (!fifo_empty) bus.resp_valid[head] = bus.mem_resp_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      locked <= 1'b0;
      lock_g <= '0;
    end else if (hs) begin
      rr_ptr <= (g == P'(NUM_PORTS-1)) ? '0 : g + 1'b1;
      locked <= 1'b0;
    end else if (bus.mem_req_valid) begin
      locked <= 1'b1;
      lock_g <= g;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.mem_resp_valid && fifo_empty) protocol_error <= 1'b1;
    end
  end

`ifdef BASILISK_MEMORY_ARBITER_STATS_EN
  logic conflict, full_stall;
  assign conflict   = ($countones(bus.req_valid) > 1);
  assign full_stall = fifo_full && |(bus.req_valid & bus.req_read_enable);

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count   <= '0;
      full_stall_count <= '0;
    end else begin
      if (conflict && conflict_count != '1)     conflict_count   <= conflict_count + 1'b1;
      if (full_stall && full_stall_count != '1) full_stall_count <= full_stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_basilisk_memory_arbiter.sv
// Directed bench for basilisk_memory_arbiter; stimulus queues expectations, a monitor checks handshakes.
module tb_basilisk_memory_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic perr;
  always #5 clk = ~clk;

  basilisk_memory_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

`ifdef BASILISK_MEMORY_ARBITER_STATS_EN
  logic [31:0] conflict_count, full_stall_count;
`endif

  basilisk_memory_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
`ifdef BASILISK_MEMORY_ARBITER_STATS_EN
    .conflict_count(conflict_count),
    .full_stall_count(full_stall_count),
`endif
    .protocol_error(perr)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] we; logic re; } req_t;
  typedef struct { int port; logic [31:0] data; } rsp_t;
  req_t rq[$];
  rsp_t sq[$];
  int cmp = 0;
  int bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(int p, bit v, bit re, logic [3:0] we, logic [31:0] a, logic [31:0] d);
    bus.req_valid[p]              = v;
    bus.req_read_enable[p]        = re;
    bus.req_write_enable[p*4 +: 4] = we;
    bus.req_addr[p*32 +: 32]      = a;
    bus.req_data[p*32 +: 32]      = d;
  endtask

  task automatic exp_req(logic [31:0] a, logic [31:0] d, logic [3:0] we, logic re);
    req_t r;
    r.addr = a; r.data = d; r.we = we; r.re = re;
    rq.push_back(r);
  endtask

  task automatic exp_rsp(int p, logic [31:0] d);
    rsp_t s;
    s.port = p; s.data = d;
    sq.push_back(s);
  endtask

  // Monitor: every request/response handshake must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (rq.size() == 0) begin
          cmp++; bad++;
          $display("FAIL req_unexpected: got addr %h expected no request", bus.mem_req_addr);
        end else begin
          req_t r;
          r = rq.pop_front();
          chk("req_addr", bus.mem_req_addr, r.addr);
          chk("req_data", bus.mem_req_data, r.data);
          chk("req_we", {28'd0, bus.mem_req_write_enable}, {28'd0, r.we});
          chk("req_re", {31'd0, bus.mem_req_read_enable}, {31'd0, r.re});
        end
      end
      if (|(bus.resp_valid & bus.resp_ready)) begin
        if (sq.size() == 0) begin
          cmp++; bad++;
          $display("FAIL rsp_unexpected: got data %h expected no response", bus.resp_data);
        end else begin
          rsp_t s;
          int p;
          s = sq.pop_front();
          p = bus.resp_valid[1] ? 1 : 0;
          chk("rsp_port", p, s.port);
          chk("rsp_data", bus.resp_data, s.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = '0; bus.req_read_enable = '0; bus.req_write_enable = '0;
    bus.req_addr = '0; bus.req_data = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.resp_ready = '0;
    repeat (3) step();
    rst = 1'b0;
    settle();
    chk("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 0);
    chk("rst_req_ready", {30'd0, bus.req_ready}, 0);
    chk("rst_resp_valid", {30'd0, bus.resp_valid}, 0);
    chk("rst_mem_resp_ready", {31'd0, bus.mem_resp_ready}, 0);
    chk("rst_perr", {31'd0, perr}, 0);
    step();

    // T1: simultaneous reads, rr_ptr=0
    bus.mem_req_ready = 1'b1;
    set_port(0, 1, 1, 4'h0, 32'h100, 0);
    set_port(1, 1, 1, 4'h0, 32'h200, 0);
    exp_req(32'h100, 0, 4'h0, 1); exp_req(32'h200, 0, 4'h0, 1);
    settle(); chk("t1_ready0", {30'd0, bus.req_ready}, 1);
    step(); set_port(0, 0, 0, 0, 0, 0);
    settle(); chk("t1_ready1", {30'd0, bus.req_ready}, 2);
    step(); set_port(1, 0, 0, 0, 0, 0);
    bus.resp_ready = 2'b11; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hAAAA;
    exp_rsp(0, 32'hAAAA); exp_rsp(1, 32'hBBBB);
    settle(); chk("t1_rv0", {30'd0, bus.resp_valid}, 1);
    step(); bus.mem_resp_data = 32'hBBBB;
    settle(); chk("t1_rv1", {30'd0, bus.resp_valid}, 2);
    step(); bus.mem_resp_valid = 1'b0;

    // T2: lone port1 granted, rr_ptr wraps back to 0
    set_port(1, 1, 0, 4'hF, 32'h300, 32'h1234);
    exp_req(32'h300, 32'h1234, 4'hF, 0);
    settle(); chk("t2_ready", {30'd0, bus.req_ready}, 2);
    step();
    set_port(0, 1, 0, 4'h3, 32'h400, 32'h4444);
    set_port(1, 1, 0, 4'hC, 32'h500, 32'h5555);
    exp_req(32'h400, 32'h4444, 4'h3, 0); exp_req(32'h500, 32'h5555, 4'hC, 0);
    settle(); chk("t2_rr0", {30'd0, bus.req_ready}, 1);
    step(); set_port(0, 0, 0, 0, 0, 0);
    settle(); chk("t2_rr1", {30'd0, bus.req_ready}, 2);
    step(); set_port(1, 0, 0, 0, 0, 0);

    // T3: stalled grant is held for 3 cycles
    bus.mem_req_ready = 1'b0;
    set_port(0, 1, 1, 4'h0, 32'h600, 0);
    exp_req(32'h600, 0, 4'h0, 1);
    settle();
    chk("t3_valid", {31'd0, bus.mem_req_valid}, 1);
    chk("t3_addr_c0", bus.mem_req_addr, 32'h600);
    chk("t3_ready_c0", {30'd0, bus.req_ready}, 0);
    step();
    set_port(1, 1, 1, 4'h0, 32'h700, 0);
    exp_req(32'h700, 0, 4'h0, 1);
    for (int c = 1; c < 3; c++) begin
      settle();
      chk("t3_addr_hold", bus.mem_req_addr, 32'h600);
      chk("t3_ready_hold", {30'd0, bus.req_ready}, 0);
      step();
    end
    bus.mem_req_ready = 1'b1;
    settle(); chk("t3_accept", {30'd0, bus.req_ready}, 1);
    step(); set_port(0, 0, 0, 0, 0, 0);
    settle(); chk("t3_next", {30'd0, bus.req_ready}, 2);
    chk("t3_next_addr", bus.mem_req_addr, 32'h700);
    step(); set_port(1, 0, 0, 0, 0, 0);

    // T4: fill to 4 outstanding, 5th read stalls while a write passes
    set_port(0, 1, 1, 4'h0, 32'h800, 0); exp_req(32'h800, 0, 4'h0, 1);
    settle(); chk("t4_r3", {30'd0, bus.req_ready}, 1);
    step(); set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 1, 1, 4'h0, 32'h900, 0); exp_req(32'h900, 0, 4'h0, 1);
    settle(); chk("t4_r4", {30'd0, bus.req_ready}, 2);
    step(); set_port(1, 0, 0, 0, 0, 0);
    set_port(0, 1, 1, 4'h0, 32'hA00, 0);
    set_port(1, 1, 0, 4'hF, 32'hC0, 32'hDEAD);
    exp_req(32'hC0, 32'hDEAD, 4'hF, 0); exp_req(32'hA00, 0, 4'h0, 1);
    settle(); chk("t4_write_passes", {30'd0, bus.req_ready}, 2);
    step(); set_port(1, 0, 0, 0, 0, 0);
    settle();
    chk("t4_read_stall", {30'd0, bus.req_ready}, 0);
    chk("t4_no_valid", {31'd0, bus.mem_req_valid}, 0);
    step();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1111; bus.resp_ready = 2'b11;
    exp_rsp(0, 32'h1111);
    settle(); chk("t4_pop_still_full", {30'd0, bus.req_ready}, 0);
    step(); bus.mem_resp_valid = 1'b0;
    settle(); chk("t4_read_after_pop", {30'd0, bus.req_ready}, 1);
    step(); set_port(0, 0, 0, 0, 0, 0);

    // T5: head port (1) not ready holds the beat
    bus.resp_ready = 2'b01; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h2222;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("t5_rv", {30'd0, bus.resp_valid}, 2);
      chk("t5_mrr", {31'd0, bus.mem_resp_ready}, 0);
      chk("t5_data", bus.resp_data, 32'h2222);
      step();
    end
    bus.resp_ready = 2'b11; exp_rsp(1, 32'h2222);
    settle(); chk("t5_release", {31'd0, bus.mem_resp_ready}, 1);
    step();
    for (int c = 0; c < 3; c++) begin
      logic [31:0] d;
      int p;
      d = 32'h3333 + 32'h1111 * c;
      p = (c == 1) ? 1 : 0;
      bus.mem_resp_data = d; exp_rsp(p, d);
      settle(); chk("t5_drain", {30'd0, bus.resp_valid}, (p == 1) ? 2 : 1);
      step();
    end
    bus.mem_resp_valid = 1'b0;

    // T6: stray response while empty
    bus.resp_ready = 2'b00; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hBAD;
    settle();
    chk("t6_mrr", {31'd0, bus.mem_resp_ready}, 1);
    chk("t6_rv", {30'd0, bus.resp_valid}, 0);
    step(); bus.mem_resp_valid = 1'b0;
    settle(); chk("t6_perr_set", {31'd0, perr}, 1);
    step(); step();
    settle(); chk("t6_perr_sticky", {31'd0, perr}, 1);
    rst = 1'b1; step(); rst = 1'b0;
    settle();
    chk("t6_perr_clr", {31'd0, perr}, 0);
    chk("t6_mem_req_valid", {31'd0, bus.mem_req_valid}, 0);
    step();

    chk("req_queue_drained", rq.size(), 0);
    chk("rsp_queue_drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
